// File: rtl/div_pkg.sv
// Purpose : shared FSM state type and default widths for the subtractive divider.
// Latency : n/a (types and constants only).
// Backpressure : n/a.
package div_pkg;

   localparam int DW_DEF = 5;   // dividend / quotient width
   localparam int VW_DEF = 4;   // divisor / remainder width

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage

// File: rtl/subtractive_divider_if.sv
// Purpose : request/result bundle between a divider client (master) and the divider (slave).
// Latency : n/a (wiring only).
// Backpressure : start is only taken while the divider is idle; busy shows when it is not.
// Signals: start/dividend/divisor (master->slave), busy/done/quotient/remainder/err (slave->master).
interface subtractive_divider_if #(
   parameter int DW = div_pkg::DW_DEF,
   parameter int VW = div_pkg::VW_DEF
);
   logic          start;
   logic [DW-1:0] dividend;
   logic [VW-1:0] divisor;
   logic          busy;
   logic          done;
   logic [DW-1:0] quotient;
   logic [VW-1:0] remainder;
   logic          err;

   modport master (
      output start, dividend, divisor,
      input  busy, done, quotient, remainder, err
   );

   modport slave (
      input  start, dividend, divisor,
      output busy, done, quotient, remainder, err
   );
endinterface

// File: rtl/subtractor_struct.sv
// Purpose : W-bit ripple-borrow subtractor a_i - b_i built from full-subtractor cells.
// Latency : combinational.
// Backpressure : n/a.
// Ports: a_i, b_i (minuend, subtrahend), diff_o (a-b mod 2^W), borrow_o (1 when a_i < b_i unsigned).
module subtractor_struct #(
   parameter int W = div_pkg::DW_DEF
) (
   input  logic [W-1:0] a_i,
   input  logic [W-1:0] b_i,
   output logic [W-1:0] diff_o,
   output logic         borrow_o
);

   logic [W:0] bw;

   assign bw[0] = 1'b0;

   for (genvar i = 0; i < W; i++) begin : g_cell
      assign diff_o[i] = a_i[i] ^ b_i[i] ^ bw[i];
      // Borrow out when a<b at this bit, or bits equal and a borrow ripples in.
      assign bw[i+1]   = (~a_i[i] & b_i[i]) | (~(a_i[i] ^ b_i[i]) & bw[i]);
   end

   assign borrow_o = bw[W];

endmodule

// File: rtl/subtractive_divider.sv
// Purpose : unsigned divider by repeated subtraction (IDLE -> RUN -> DONE).
// Latency : done pulses quotient+2 cycles after the accepting cycle (1 for a trapped divide-by-zero).
// Backpressure : start is taken only in IDLE; start while busy or in DONE is dropped, not queued.
// Ports: clk, rst (async active-high), bus (slave side of subtractive_divider_if).
// Build option: define SUB_DIV_DBZ_EN to trap divisor==0 with err; otherwise err is 0 and a
// zero divisor runs until the quotient saturates.
module subtractive_divider
   import div_pkg::*;
#(
   parameter int DW = DW_DEF,
   parameter int VW = VW_DEF
) (
   input  logic                   clk,
   input  logic                   rst,
   subtractive_divider_if.slave   bus
);

   localparam logic [DW-1:0] Q_MAX = '1;

   state_t        state_q;
   logic [DW-1:0] r_q;
   logic [VW-1:0] d_q;
   logic [DW-1:0] q_q;
   logic          busy_q;
   logic          done_q;

   logic [DW-1:0] diff_d;
   logic          borrow_d;

   // Remainder minus zero-extended divisor; the borrow doubles as the R<D compare.
   subtractor_struct #(.W(DW)) u_sub (
      .a_i      (r_q),
      .b_i      (DW'(d_q)),
      .diff_o   (diff_d),
      .borrow_o (borrow_d)
   );

`ifdef SUB_DIV_DBZ_EN
   logic err_q;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         r_q     <= '0;
         d_q     <= '0;
         q_q     <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
`ifdef SUB_DIV_DBZ_EN
         err_q   <= 1'b0;
`endif
      end else begin
         case (state_q)
            IDLE: begin
               if (bus.start) begin
`ifdef SUB_DIV_DBZ_EN
                  if (bus.divisor == '0) begin
                     r_q     <= '0;
                     d_q     <= '0;
                     q_q     <= '0;
                     done_q  <= 1'b1;
                     err_q   <= 1'b1;
                     state_q <= DONE;
                  end else
`endif
                  begin
                     r_q     <= bus.dividend;
                     d_q     <= bus.divisor;
                     q_q     <= '0;
                     busy_q  <= 1'b1;
                     state_q <= RUN;
                  end
               end
            end
            RUN: begin
               // Saturation stops a zero divisor from looping forever.
               if (!borrow_d && (q_q != Q_MAX)) begin
                  r_q <= diff_d;
                  q_q <= q_q + DW'(1);
               end else begin
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  state_q <= DONE;
               end
            end
            DONE: begin
               done_q  <= 1'b0;
`ifdef SUB_DIV_DBZ_EN
               err_q   <= 1'b0;
`endif
               state_q <= IDLE;
            end
            default: begin
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign bus.busy      = busy_q;
   assign bus.done      = done_q;
   assign bus.quotient  = q_q;
   assign bus.remainder = r_q[VW-1:0];
`ifdef SUB_DIV_DBZ_EN
   assign bus.err       = err_q;
`else
   assign bus.err       = 1'b0;
`endif

endmodule

// File: tb/tb_subtractive_divider.sv
module tb_subtractive_divider;

   localparam int DW = 5;
   localparam int VW = 4;

   logic clk = 1'b0;
   logic rst;
   int   checks   = 0;
   int   failures = 0;

   always #5 clk = ~clk;

   subtractive_divider_if #(.DW(DW), .VW(VW)) bus ();

   subtractive_divider #(.DW(DW), .VW(VW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Reference: plain integer division, with the zero-divisor behaviour of the build.
   task automatic model(input int a, input int b,
                        output int eq, output int er, output int ee, output int el);
      if (b == 0) begin
`ifdef SUB_DIV_DBZ_EN
         eq = 0; er = 0; ee = 1; el = 1;
`else
         eq = (1 << DW) - 1; er = a % (1 << VW); ee = 0; el = eq + 2;
`endif
      end else begin
         eq = a / b; er = a % b; ee = 0; el = eq + 2;
      end
   endtask

   task automatic run_op(input int a, input int b, input string tag);
      int eq, er, ee, el, lat, nb;
      bit seen;
      model(a, b, eq, er, ee, el);
      @(negedge clk);
      bus.dividend = DW'(a);
      bus.divisor  = VW'(b);
      bus.start    = 1'b1;
      @(posedge clk); #1;
      // Inputs after acceptance must not matter.
      bus.start    = 1'b0;
      bus.dividend = DW'($urandom);
      bus.divisor  = VW'($urandom);
      lat = 1; nb = 0; seen = 1'b0;
      for (int i = 0; i < 200 && !seen; i++) begin
         if (bus.done) seen = 1'b1;
         else begin
            if (bus.busy) nb++;
            @(posedge clk); #1;
            lat++;
         end
      end
      check({tag, " done_seen"}, 32'(seen), 32'd1);
      check({tag, " latency"}, lat, el);
      check({tag, " busy_cycles"}, nb, (ee != 0) ? 0 : eq + 1);
      check({tag, " quotient"}, 32'(bus.quotient), eq);
      check({tag, " remainder"}, 32'(bus.remainder), er);
      check({tag, " err"}, 32'(bus.err), ee);
      check({tag, " busy_in_done"}, 32'(bus.busy), 32'd0);
      @(posedge clk); #1;
      check({tag, " done_one_cycle"}, 32'(bus.done), 32'd0);
      check({tag, " err_cleared"}, 32'(bus.err), 32'd0);
      check({tag, " quotient_hold"}, 32'(bus.quotient), eq);
      check({tag, " remainder_hold"}, 32'(bus.remainder), er);
   endtask

   initial begin
      int ndone;
      rst          = 1'b1;
      bus.start    = 1'b0;
      bus.dividend = '0;
      bus.divisor  = '0;
      repeat (2) @(posedge clk);
      #1;
      check("reset busy", 32'(bus.busy), 32'd0);
      check("reset done", 32'(bus.done), 32'd0);
      check("reset quotient", 32'(bus.quotient), 32'd0);
      check("reset remainder", 32'(bus.remainder), 32'd0);
      check("reset err", 32'(bus.err), 32'd0);
      @(negedge clk);
      rst = 1'b0;

      run_op(23, 4, "div_23_4");
      run_op(31, 1, "div_31_1");

      // Start held high through RUN and DONE must be dropped.
      @(negedge clk);
      bus.dividend = 5'd3; bus.divisor = 4'd7; bus.start = 1'b1;
      @(posedge clk); #1;
      check("ign busy_run", 32'(bus.busy), 32'd1);
      bus.dividend = 5'd20; bus.divisor = 4'd5;
      @(posedge clk); #1;
      check("ign done_lat2", 32'(bus.done), 32'd1);
      check("ign quotient", 32'(bus.quotient), 32'd0);
      check("ign remainder", 32'(bus.remainder), 32'd3);
      @(posedge clk); #1;
      check("ign not_accepted_busy", 32'(bus.busy), 32'd0);
      check("ign not_accepted_q", 32'(bus.quotient), 32'd0);
      check("ign not_accepted_r", 32'(bus.remainder), 32'd3);
      bus.start = 1'b0;
      run_op(20, 5, "div_20_5");

      run_op(0, 0, "div_0_0");
      run_op(27, 0, "div_27_0");

      // Asynchronous reset between edges mid-RUN.
      @(negedge clk);
      bus.dividend = 5'd30; bus.divisor = 4'd2; bus.start = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
      @(posedge clk); @(posedge clk); #2;
      rst = 1'b1;
      #1;
      check("arst busy", 32'(bus.busy), 32'd0);
      check("arst done", 32'(bus.done), 32'd0);
      check("arst quotient", 32'(bus.quotient), 32'd0);
      check("arst remainder", 32'(bus.remainder), 32'd0);
      check("arst err", 32'(bus.err), 32'd0);
      @(negedge clk); @(negedge clk);
      rst = 1'b0;
      ndone = 0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk); #1;
         if (bus.done || bus.busy) ndone++;
      end
      check("arst no_done_after", ndone, 0);
      run_op(9, 2, "div_9_2");

      for (int k = 0; k < 10; k++) begin
         int a, b;
         a = int'($urandom_range(31, 0));
         b = int'($urandom_range(15, 0));
         run_op(a, b, $sformatf("rand%0d_%0d_%0d", k, a, b));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
